router_out_arbiter: RTL and testbench
=====================================

Name: router_out_arbiter

Overview:
- Drains the three router output FIFOs (channels 0..2) into one shared 8-bit egress port.
- Generates read_enb_0..2 from the FIFOs' vld_out_x.
- Arbitrates round-robin with whole-packet locking, so bytes of different packets never interleave.
- Tags every egress byte with source, start-of-packet and end-of-packet. The header byte's payload length, data[7:2], sizes each transfer.

Parameters:
- RR_EN, 1: 1 = round-robin priority; 0 = fixed priority 0 > 1 > 2.
- OBUF_DEPTH, 2: egress buffer entries. Only 2 is supported; it sizes the occupancy counter.

Ports:
- router_clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- vld_out_0, vld_out_1, vld_out_2  in  1 each  FIFO x not empty
- data_out_0, data_out_1, data_out_2  in  8 each  FIFO x read data, valid the cycle after read_enb_x
- soft_reset_0, soft_reset_1, soft_reset_2  in  1 each  FIFO x flushed this cycle
- read_enb_0, read_enb_1, read_enb_2  out  1 each  FIFO read strobes; at most one high per cycle
- port_data  out  8  egress byte
- port_valid  out  1  egress byte valid
- port_ready  in  1  egress sink accepts byte
- port_sop  out  1  byte is a header
- port_eop  out  1  byte is a parity (last) byte
- port_src  out  2  channel the byte came from
- pkt_abort  out  1  one-cycle pulse: granted packet truncated by soft reset
- busy_grant  out  1  a packet is locked

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE, rr_ptr=0, occupancy=0, buffer empty.
  - All outputs are 0: read_enb_x, port_valid, port_sop, port_eop, pkt_abort, busy_grant, port_data=8'h00, port_src=2'd0.
- Occupancy and read issue:
  - occ = bytes buffered + reads in flight (0..2).
  - pop = port_valid & port_ready.
  - A read may issue only when (occ<2 | pop) and vld_out of the granted channel is 1.
  - occ +1 on issue, -1 on pop; both together leave occ unchanged.
  - Capture: the byte read at cycle t is latched from data_out_g at the end of t+1 and is visible on port_data in t+2.
  - Buffer is FIFO ordered; port_data, port_sop, port_eop and port_src must hold stable while port_valid & !port_ready.
- FSM:
  - IDLE:
    - If any vld_out_x: grant the first asserted channel searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); with RR_EN=0 the search starts at 0.
    - Register g; set busy_grant=1; go to HDR. No read is issued in IDLE.
  - HDR:
    - Issue one read (the header) when allowed; go to WAIT_HDR.
  - WAIT_HDR:
    - No read issued.
    - At the end of this cycle capture the header (sop=1, src=g) and load rem = data_out_g[7:2] + 1 (payload + parity; length 0 gives rem=1).
    - Go to BODY.
  - BODY:
    - Issue a read whenever allowed; rem decrements per issue.
    - The read issued with rem==1 is tagged eop=1.
    - After issuing it: rr_ptr = g+1 mod 3 (RR_EN=1), busy_grant=0, go to IDLE.
    - Buffered bytes keep draining after release.
    - The next grant can be made the following cycle; its header read issues in HDR only if occ allows.
- vld_out_g low mid-packet: stall reads with no timeout; the grant is held.
- soft_reset_g=1 while state != IDLE:
  - Cancel remaining reads; any read issued this same cycle is discarded on return (occ corrected).
  - Pulse pkt_abort; go to IDLE; rr_ptr advances as on normal completion.
  - Bytes already buffered still drain, and none is marked eop.
- soft_reset on a non-granted channel: ignored.
- Simultaneous vld_out on all channels with rr_ptr=2: grant order 2, 0, 1.

Test Plan:
- Single packet, channel 1, header 8'h0D (len 3), port_ready=1:
  - read_enb_1 high for 5 issue cycles (header, then 3 payload + parity after one bubble).
  - port_sop on byte 0; port_eop on byte 4 (parity); port_src=1 throughout; no other read_enb high.
- All three vld_out high, each with a len-2 packet, from reset:
  - egress packet order src 0, 1, 2, 0...; rr_ptr=0 after the third packet.
  - no byte interleaving.
- Backpressure: port_ready low for 10 cycles mid-payload:
  - at most 2 read_enb pulses since the last pop; port_data stable for all 10 cycles.
  - no byte lost or duplicated once ready returns.
- vld_out_2 drops for 4 cycles mid-body:
  - read_enb_2 low those 4 cycles; the grant is held, busy_grant=1, and the rest of the packet continues intact.
- soft_reset_0 asserted after 2 payload reads of a len-6 packet:
  - pkt_abort one cycle; no further read_enb_0.
  - header plus bytes already read still delivered; no port_eop.
  - next pending channel granted.
- resetn low for 1 cycle mid-packet:
  - all outputs 0 immediately (asynchronous); the next grant after reset uses rr_ptr=0.

Source files
------------

// File: rtl/router_out_arbiter_if.sv
// Egress port of the router output arbiter: one tagged byte per valid/ready beat.
interface router_out_arbiter_if;
   logic [7:0] port_data;
   logic       port_valid;
   logic       port_ready;
   logic       port_sop;
   logic       port_eop;
   logic [1:0] port_src;

   modport master (
      output port_data, port_valid, port_sop, port_eop, port_src,
      input  port_ready
   );

   modport slave (
      input  port_data, port_valid, port_sop, port_eop, port_src,
      output port_ready
   );
endinterface

// File: rtl/router_out_arbiter.sv
// Drains three router output FIFOs into one egress port, round-robin with whole-packet
// locking; every egress byte carries its source channel and start/end-of-packet tags.
module router_out_arbiter #(
   parameter int unsigned RR_EN      = 1,
   parameter int unsigned OBUF_DEPTH = 2
) (
   input  logic                        router_clock,
   input  logic                        resetn,
   input  logic                        vld_out_0,
   input  logic                        vld_out_1,
   input  logic                        vld_out_2,
   input  logic [7:0]                  data_out_0,
   input  logic [7:0]                  data_out_1,
   input  logic [7:0]                  data_out_2,
   input  logic                        soft_reset_0,
   input  logic                        soft_reset_1,
   input  logic                        soft_reset_2,
   output logic                        read_enb_0,
   output logic                        read_enb_1,
   output logic                        read_enb_2,
   router_out_arbiter_if.master        port,
   output logic                        pkt_abort,
   output logic                        busy_grant
);

   localparam int unsigned OCC_W = $clog2(OBUF_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, HDR, WAIT_HDR, BODY} state_e;

   state_e           state_q, state_d;
   logic [1:0]       g_q, g_d, rr_q, rr_d;
   logic [6:0]       rem_q, rem_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             pkt_abort_q, pkt_abort_d, busy_q, busy_d;
   logic             p_vld_q, p_vld_d, p_sop_q, p_sop_d, p_eop_q, p_eop_d;
   logic [1:0]       p_src_q, p_src_d;
   logic [7:0]       b_data_q [2];
   logic [7:0]       b_data_d [2];
   logic [1:0]       b_src_q [2];
   logic [1:0]       b_src_d [2];
   logic [1:0]       b_sop_q, b_sop_d, b_eop_q, b_eop_d;
   logic             b_wr_q, b_wr_d, b_rd_q, b_rd_d;
   logic [1:0]       b_cnt_q, b_cnt_d;

   logic [2:0] vld, srst, rd_en;
   logic [7:0] din [3];
   logic       pop, room, issue, abort, found;
   logic [1:0] pick, next_rr, release_rr;

   always_comb begin
      vld     = {vld_out_2, vld_out_1, vld_out_0};
      srst    = {soft_reset_2, soft_reset_1, soft_reset_0};
      din[0]  = data_out_0;
      din[1]  = data_out_1;
      din[2]  = data_out_2;
      pop     = (b_cnt_q != 2'd0) & port.port_ready;
      room    = (occ_q < OCC_W'(OBUF_DEPTH)) | pop;
      issue   = ((state_q == HDR) | (state_q == BODY)) & room & vld[g_q];
      abort   = (state_q != IDLE) & srst[g_q];
      rd_en   = issue ? (3'b001 << g_q) : 3'b000;
      next_rr = (g_q == 2'd2) ? 2'd0 : g_q + 2'd1;
      release_rr = (RR_EN != 0) ? next_rr : rr_q;
   end

   always_comb begin
      int unsigned idx;
      logic [1:0]  sel;
      idx   = 0;
      sel   = '0;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         idx = (((RR_EN != 0) ? int'(rr_q) : 0) + i) % 3;
         sel = 2'(idx);
         if (!found && vld[sel]) begin
            pick  = sel;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      rr_d        = rr_q;
      rem_d       = rem_q;
      pkt_abort_d = 1'b0;
      unique case (state_q)
         IDLE: if (found) begin
            g_d     = pick;
            state_d = HDR;
         end
         HDR: if (issue) state_d = WAIT_HDR;
         WAIT_HDR: begin
            rem_d   = {1'b0, din[g_q][7:2]} + 7'd1;
            state_d = BODY;
         end
         BODY: if (issue) begin
            rem_d = rem_q - 7'd1;
            if (rem_q == 7'd1) begin
               state_d = IDLE;
               rr_d    = release_rr;
            end
         end
         default: state_d = IDLE;
      endcase
      // A read issued in the abort cycle is never counted nor captured.
      if (abort) begin
         state_d     = IDLE;
         rr_d        = release_rr;
         pkt_abort_d = 1'b1;
      end
      busy_d  = (state_d != IDLE);
      occ_d   = occ_q + OCC_W'(issue & ~abort) - OCC_W'(pop);
      p_vld_d = issue & ~abort;
      p_sop_d = (state_q == HDR);
      p_eop_d = (state_q == BODY) & (rem_q == 7'd1);
      p_src_d = g_q;
   end

   always_comb begin
      b_data_d = b_data_q;
      b_src_d  = b_src_q;
      b_sop_d  = b_sop_q;
      b_eop_d  = b_eop_q;
      b_wr_d   = b_wr_q;
      b_rd_d   = b_rd_q;
      if (p_vld_q) begin
         b_data_d[b_wr_q] = din[p_src_q];
         b_src_d[b_wr_q]  = p_src_q;
         b_sop_d[b_wr_q]  = p_sop_q;
         b_eop_d[b_wr_q]  = p_eop_q;
         b_wr_d           = ~b_wr_q;
      end
      if (pop) b_rd_d = ~b_rd_q;
      b_cnt_d = b_cnt_q + 2'(p_vld_q) - 2'(pop);
   end

   always_ff @(posedge router_clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         g_q         <= '0;
         rr_q        <= '0;
         rem_q       <= '0;
         occ_q       <= '0;
         pkt_abort_q <= 1'b0;
         busy_q      <= 1'b0;
         p_vld_q     <= 1'b0;
         p_sop_q     <= 1'b0;
         p_eop_q     <= 1'b0;
         p_src_q     <= '0;
         b_data_q    <= '{default: '0};
         b_src_q     <= '{default: '0};
         b_sop_q     <= '0;
         b_eop_q     <= '0;
         b_wr_q      <= 1'b0;
         b_rd_q      <= 1'b0;
         b_cnt_q     <= '0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         rr_q        <= rr_d;
         rem_q       <= rem_d;
         occ_q       <= occ_d;
         pkt_abort_q <= pkt_abort_d;
         busy_q      <= busy_d;
         p_vld_q     <= p_vld_d;
         p_sop_q     <= p_sop_d;
         p_eop_q     <= p_eop_d;
         p_src_q     <= p_src_d;
         b_data_q    <= b_data_d;
         b_src_q     <= b_src_d;
         b_sop_q     <= b_sop_d;
         b_eop_q     <= b_eop_d;
         b_wr_q      <= b_wr_d;
         b_rd_q      <= b_rd_d;
         b_cnt_q     <= b_cnt_d;
      end
   end

   assign read_enb_0      = rd_en[0];
   assign read_enb_1      = rd_en[1];
   assign read_enb_2      = rd_en[2];
   assign port.port_valid = (b_cnt_q != 2'd0);
   assign port.port_data  = b_data_q[b_rd_q];
   assign port.port_src   = b_src_q[b_rd_q];
   assign port.port_sop   = b_sop_q[b_rd_q];
   assign port.port_eop   = b_eop_q[b_rd_q];
   assign pkt_abort       = pkt_abort_q;
   assign busy_grant      = busy_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Randomized and directed bench for router_out_arbiter against a packet-level model
// of the three FIFOs and the round-robin egress byte order.
module tb_router_out_arbiter;
   logic       router_clock = 1'b0;
   logic       resetn = 1'b1;
   logic [2:0] vld_tb, srst_tb;
   logic [7:0] din_tb [3];
   logic       vld_out_0, vld_out_1, vld_out_2;
   logic [7:0] data_out_0, data_out_1, data_out_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       read_enb_0, read_enb_1, read_enb_2;
   logic       pkt_abort, busy_grant;

   router_out_arbiter_if pif ();

   assign vld_out_0    = vld_tb[0];
   assign vld_out_1    = vld_tb[1];
   assign vld_out_2    = vld_tb[2];
   assign data_out_0   = din_tb[0];
   assign data_out_1   = din_tb[1];
   assign data_out_2   = din_tb[2];
   assign soft_reset_0 = srst_tb[0];
   assign soft_reset_1 = srst_tb[1];
   assign soft_reset_2 = srst_tb[2];

   router_out_arbiter #(.RR_EN(1), .OBUF_DEPTH(2)) dut (
      .router_clock (router_clock),
      .resetn       (resetn),
      .vld_out_0    (vld_out_0),
      .vld_out_1    (vld_out_1),
      .vld_out_2    (vld_out_2),
      .data_out_0   (data_out_0),
      .data_out_1   (data_out_1),
      .data_out_2   (data_out_2),
      .soft_reset_0 (soft_reset_0),
      .soft_reset_1 (soft_reset_1),
      .soft_reset_2 (soft_reset_2),
      .read_enb_0   (read_enb_0),
      .read_enb_1   (read_enb_1),
      .read_enb_2   (read_enb_2),
      .port         (pif),
      .pkt_abort    (pkt_abort),
      .busy_grant   (busy_grant)
   );

   always #5 router_clock = ~router_clock;

   typedef struct packed {
      logic [7:0] d;
      logic       sop;
      logic       eop;
      logic [1:0] src;
   } ent_t;

   ent_t        exp_q [$];
   logic [7:0]  fifo [3][$];
   logic [7:0]  pend_d [3];
   bit   [2:0]  pend, drop, srst_req;
   int unsigned checks = 0, errors = 0, cyc = 0, pops = 0, rdy_pct = 100;
   int          occ_m = 0;
   int unsigned rd_cnt [3];
   int unsigned rd1_cyc [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rd0"}, read_enb_0, 0);
      check({tag, "_rd1"}, read_enb_1, 0);
      check({tag, "_rd2"}, read_enb_2, 0);
      check({tag, "_valid"}, pif.port_valid, 0);
      check({tag, "_sop"}, pif.port_sop, 0);
      check({tag, "_eop"}, pif.port_eop, 0);
      check({tag, "_data"}, pif.port_data, 0);
      check({tag, "_src"}, pif.port_src, 0);
      check({tag, "_abort"}, pkt_abort, 0);
      check({tag, "_busy"}, busy_grant, 0);
   endtask

   task automatic clear_model();
      vld_tb = '0;
      srst_tb = '0;
      srst_req = '0;
      drop = '0;
      pend = '0;
      pif.port_ready = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
         din_tb[ch] = 8'h00;
         fifo[ch].delete();
         rd_cnt[ch] = 0;
      end
      exp_q.delete();
      rd1_cyc.delete();
      occ_m = 0;
      pops = 0;
   endtask

   task automatic do_reset(input bit chk_out);
      resetn = 1'b0;
      clear_model();
      #1;
      if (chk_out) check_outputs_zero("rst");
      repeat (2) @(negedge router_clock);
      resetn = 1'b1;
   endtask

   task automatic push_pkt(input int ch, input logic [7:0] hdr);
      logic [7:0] b, par;
      fifo[ch].push_back(hdr);
      par = hdr;
      for (int k = 0; k < int'(hdr[7:2]); k++) begin
         b = 8'($urandom);
         par ^= b;
         fifo[ch].push_back(b);
      end
      fifo[ch].push_back(par);
   endtask

   // Packet-level model: whole packets leave in round-robin order among non-empty channels.
   task automatic build_expected(input int unsigned rr, input bit [2:0] mask);
      logic [7:0]  lq [3][$];
      logic [7:0]  b;
      int unsigned ch, len;
      for (int c = 0; c < 3; c++) if (mask[c]) lq[c] = fifo[c];
      while (lq[0].size() + lq[1].size() + lq[2].size() != 0) begin
         ch = rr;
         for (int unsigned i = 0; i < 3; i++) begin
            if (lq[(rr + i) % 3].size() != 0) begin
               ch = (rr + i) % 3;
               break;
            end
         end
         b = lq[ch].pop_front();
         len = b[7:2];
         exp_q.push_back('{d: b, sop: 1'b1, eop: 1'b0, src: 2'(ch)});
         for (int unsigned k = 0; k <= len; k++) begin
            b = lq[ch].pop_front();
            exp_q.push_back('{d: b, sop: 1'b0, eop: (k == len), src: 2'(ch)});
         end
         rr = (ch + 1) % 3;
      end
   endtask

   task automatic tick();
      logic [2:0] rv;
      int         popd;
      ent_t       e;
      @(negedge router_clock);
      cyc++;
      for (int ch = 0; ch < 3; ch++) begin
         if (pend[ch]) begin
            din_tb[ch] = pend_d[ch];
            pend[ch] = 1'b0;
         end
         srst_tb[ch] = srst_req[ch];
         if (srst_req[ch]) fifo[ch].delete();
         vld_tb[ch] = (fifo[ch].size() != 0) && !drop[ch];
      end
      pif.port_ready = ($urandom_range(99) < rdy_pct);
      #1;
      popd = (pif.port_valid && pif.port_ready) ? 1 : 0;
      if (pif.port_valid) begin
         if (exp_q.size() == 0) check("extra_byte", pif.port_valid, 0);
         else begin
            e = exp_q[0];
            check("data", pif.port_data, e.d);
            check("sop", pif.port_sop, e.sop);
            check("eop", pif.port_eop, e.eop);
            check("src", pif.port_src, e.src);
         end
      end
      rv = {read_enb_2, read_enb_1, read_enb_0};
      if (rv != 3'b000) check("rd_onehot", $countones(rv), 1);
      for (int ch = 0; ch < 3; ch++) begin
         if (rv[ch]) begin
            check("rd_vld", vld_tb[ch], 1);
            rd_cnt[ch]++;
            if (ch == 1) rd1_cyc.push_back(cyc);
            if (fifo[ch].size() != 0) begin
               pend_d[ch] = fifo[ch].pop_front();
               pend[ch] = 1'b1;
            end
         end
      end
      occ_m = occ_m + $countones(rv) - popd;
      if (rv != 3'b000) check("occ", (occ_m <= 2), 1);
      if (popd != 0) begin
         pops++;
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
   endtask

   task automatic drain(input int unsigned max);
      int unsigned n = 0;
      while ((exp_q.size() + fifo[0].size() + fifo[1].size() + fifo[2].size() != 0) && n < max) begin
         tick();
         n++;
      end
      check("drain", exp_q.size() + fifo[0].size() + fifo[1].size() + fifo[2].size(), 0);
      repeat (4) tick();
   endtask

   initial begin
      int unsigned n;
      ent_t        e;
      do_reset(1'b1);

      // single packet on channel 1, header len 3
      rdy_pct = 100;
      push_pkt(1, 8'h0D);
      build_expected(0, 3'b111);
      drain(200);
      check("single_rd1", rd_cnt[1], 5);
      check("single_rd_other", rd_cnt[0] + rd_cnt[2], 0);
      if (rd1_cyc.size() == 5) begin
         check("hdr_bubble", rd1_cyc[1] - rd1_cyc[0], 2);
         check("body_burst", rd1_cyc[4] - rd1_cyc[1], 3);
      end

      // all channels loaded from reset: 0,1,2,0,1,2
      do_reset(1'b0);
      rdy_pct = 100;
      for (int r = 0; r < 2; r++)
         for (int ch = 0; ch < 3; ch++) push_pkt(ch, {6'd2, 2'($urandom)});
      build_expected(0, 3'b111);
      drain(500);

      // backpressure for 10 cycles mid-payload
      do_reset(1'b0);
      rdy_pct = 100;
      push_pkt(0, {6'd20, 2'b01});
      build_expected(0, 3'b111);
      n = 0;
      while (pops < 5 && n < 100) begin tick(); n++; end
      check("wait_bp", (pops >= 5), 1);
      rdy_pct = 0;
      repeat (10) begin
         tick();
         check("bp_valid", pif.port_valid, 1);
      end
      rdy_pct = 100;
      drain(300);

      // vld_out_2 drops mid-body
      do_reset(1'b0);
      rdy_pct = 100;
      push_pkt(2, {6'd10, 2'b11});
      build_expected(0, 3'b111);
      n = 0;
      while (rd_cnt[2] < 5 && n < 100) begin tick(); n++; end
      check("wait_drop", rd_cnt[2], 5);
      drop[2] = 1'b1;
      repeat (4) begin
         tick();
         check("drop_rd", read_enb_2, 0);
         check("drop_busy", busy_grant, 1);
      end
      drop[2] = 1'b0;
      drain(300);
      check("drop_total_rd", rd_cnt[2], 12);

      // soft reset after two payload reads, channel 2 waiting
      do_reset(1'b0);
      rdy_pct = 100;
      push_pkt(0, {6'd6, 2'b10});
      for (int k = 0; k < 3; k++) begin
         e = '{d: fifo[0][k], sop: (k == 0), eop: 1'b0, src: 2'd0};
         exp_q.push_back(e);
      end
      push_pkt(2, {6'd1, 2'b00});
      build_expected(0, 3'b100);
      n = 0;
      while (rd_cnt[0] < 3 && n < 100) begin tick(); n++; end
      check("wait_sr", rd_cnt[0], 3);
      srst_req[0] = 1'b1;
      tick();
      srst_req[0] = 1'b0;
      tick();
      check("abort_pulse", pkt_abort, 1);
      check("abort_busy", busy_grant, 0);
      tick();
      check("abort_clear", pkt_abort, 0);
      drain(300);
      check("abort_no_rd", rd_cnt[0], 3);

      // asynchronous reset mid-packet; rr pointer must restart at 0
      do_reset(1'b0);
      rdy_pct = 100;
      push_pkt(0, {6'd1, 2'b00});
      push_pkt(1, {6'd8, 2'b01});
      build_expected(0, 3'b111);
      n = 0;
      while (rd_cnt[1] < 4 && n < 100) begin tick(); n++; end
      check("wait_mid", rd_cnt[1], 4);
      #2;
      resetn = 1'b0;
      #1;
      check_outputs_zero("async");
      clear_model();
      @(negedge router_clock);
      resetn = 1'b1;
      rdy_pct = 100;
      for (int ch = 0; ch < 3; ch++) push_pkt(ch, {6'd1, 2'($urandom)});
      build_expected(0, 3'b111);
      drain(300);

      // randomized packets and egress backpressure
      for (int r = 0; r < 3; r++) begin
         do_reset(1'b0);
         for (int ch = 0; ch < 3; ch++) begin
            n = $urandom_range(1, 4);
            repeat (n) push_pkt(ch, {6'($urandom_range(0, 9)), 2'($urandom)});
         end
         build_expected(0, 3'b111);
         rdy_pct = $urandom_range(30, 90);
         drain(4000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
